sram_tp_be_arb: RTL and testbench

Round-robin arbiter that shares one two-port byte-enable SRAM (one write port, one read port, 1-cycle read latency) between REQ_NUM requesters. It arbitrates the write and read ports independently each cycle and drives the SRAM command directly. It returns read data tagged with the requester index. It sits between the encoder's line/reference buffer clients and the SRAM macro wrapper.

---
 rtl/sram_tp_be_arb.sv | 126 ++++++++++++
 tb/tb_sram_tp_be_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_tp_be_arb.sv
// Round-robin arbiter sharing one two-port byte-enable SRAM (1 write, 1 read port) between REQ_NUM requesters.
// Latency: grants and SRAM command are combinational; read data returns 1 cycle after the read grant, tagged with rd_id.
// Backpressure: requesters hold req/payload until gnt; optional macro SRAM_TP_BE_ARB_BYPASS_EN merges same-cycle write data into colliding reads.
module sram_tp_be_arb #(
    parameter int REQ_NUM = 4,
    parameter int ADR_WD  = 6,
    parameter int DAT_WD  = 32,
    parameter int COL_WD  = 8,
    parameter int BE_WD   = DAT_WD / COL_WD,
    parameter int ID_WD   = $clog2(REQ_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQ_NUM-1:0]         wr_req,
    input  logic [REQ_NUM*ADR_WD-1:0]  wr_adr,
    input  logic [REQ_NUM*DAT_WD-1:0]  wr_dat,
    input  logic [REQ_NUM*BE_WD-1:0]   wr_be,
    output logic [REQ_NUM-1:0]         wr_gnt,
    input  logic [REQ_NUM-1:0]         rd_req,
    input  logic [REQ_NUM*ADR_WD-1:0]  rd_adr,
    output logic [REQ_NUM-1:0]         rd_gnt,
    output logic                       rd_vld,
    output logic [ID_WD-1:0]           rd_id,
    output logic [DAT_WD-1:0]          rd_dat,
    output logic                       sram_wr_ena,
    output logic [ADR_WD-1:0]          sram_wr_adr,
    output logic [DAT_WD-1:0]          sram_wr_dat,
    output logic [BE_WD-1:0]           sram_wr_be,
    output logic                       sram_rd_ena,
    output logic [ADR_WD-1:0]          sram_rd_adr,
    input  logic [DAT_WD-1:0]          sram_rd_dat
);

    logic [ID_WD-1:0] wr_ptr;
    logic [ID_WD-1:0] rd_ptr;
    logic [ID_WD-1:0] wr_idx;
    logic [ID_WD-1:0] rd_idx;
    logic             wr_hit;
    logic             rd_hit;

    // Returns {hit, index}; scanning offsets high-to-low leaves the closest requester at or above ptr.
    function automatic logic [ID_WD:0] rr_pick(input logic [REQ_NUM-1:0] req,
                                               input logic [ID_WD-1:0]   ptr);
        logic [ID_WD:0] res;
        int             k;
        res = '0;
        for (int off = REQ_NUM - 1; off >= 0; off--) begin
            k = int'(ptr) + off;
            if (k >= REQ_NUM) k = k - REQ_NUM;
            if (req[k]) res = {1'b1, ID_WD'(k)};
        end
        return res;
    endfunction

    function automatic logic [ID_WD-1:0] ptr_next(input logic [ID_WD-1:0] idx);
        return (int'(idx) == REQ_NUM - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        {wr_hit, wr_idx} = rr_pick(wr_req, wr_ptr);
        {rd_hit, rd_idx} = rr_pick(rd_req, rd_ptr);
    end

    assign wr_gnt      = wr_hit ? (REQ_NUM'(1) << wr_idx) : '0;
    assign rd_gnt      = rd_hit ? (REQ_NUM'(1) << rd_idx) : '0;
    assign sram_wr_ena = wr_hit;
    assign sram_rd_ena = rd_hit;

    always_comb begin
        sram_wr_adr = '0;
        sram_wr_dat = '0;
        sram_wr_be  = '0;
        sram_rd_adr = '0;
        if (wr_hit) begin
            sram_wr_adr = wr_adr[int'(wr_idx)*ADR_WD +: ADR_WD];
            sram_wr_dat = wr_dat[int'(wr_idx)*DAT_WD +: DAT_WD];
            sram_wr_be  = wr_be[int'(wr_idx)*BE_WD +: BE_WD];
        end
        if (rd_hit) begin
            sram_rd_adr = rd_adr[int'(rd_idx)*ADR_WD +: ADR_WD];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_vld <= 1'b0;
            rd_id  <= '0;
        end else begin
            if (wr_hit) wr_ptr <= ptr_next(wr_idx);
            if (rd_hit) rd_ptr <= ptr_next(rd_idx);
            rd_vld <= rd_hit;
            rd_id  <= rd_idx;
        end
    end

`ifdef SRAM_TP_BE_ARB_BYPASS_EN
    logic              byp_hit;
    logic [DAT_WD-1:0] byp_dat;
    logic [BE_WD-1:0]  byp_be;

    // The SRAM returns pre-write data on a same-address collision; patch the written columns in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit <= 1'b0;
            byp_dat <= '0;
            byp_be  <= '0;
        end else begin
            byp_hit <= wr_hit && rd_hit && (sram_wr_adr == sram_rd_adr);
            byp_dat <= sram_wr_dat;
            byp_be  <= sram_wr_be;
        end
    end

    always_comb begin
        rd_dat = sram_rd_dat;
        for (int c = 0; c < BE_WD; c++) begin
            if (byp_hit && byp_be[c]) rd_dat[c*COL_WD +: COL_WD] = byp_dat[c*COL_WD +: COL_WD];
        end
    end
`else
    assign rd_dat = sram_rd_dat;
`endif

endmodule

// File: tb/tb_sram_tp_be_arb.sv
// Bench for sram_tp_be_arb: directed steps then 10k random cycles against a reference model and SRAM model.
module tb_sram_tp_be_arb;
    localparam int N  = 4;
    localparam int A  = 6;
    localparam int D  = 32;
    localparam int C  = 8;
    localparam int B  = D / C;
    localparam int IW = $clog2(N);
`ifdef SRAM_TP_BE_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   wr_req, rd_req, wr_gnt, rd_gnt;
    logic [N*A-1:0] wr_adr, rd_adr;
    logic [N*D-1:0] wr_dat;
    logic [N*B-1:0] wr_be;
    logic           rd_vld, sram_wr_ena, sram_rd_ena;
    logic [IW-1:0]  rd_id;
    logic [D-1:0]   rd_dat, sram_wr_dat, sram_rd_dat;
    logic [A-1:0]   sram_wr_adr, sram_rd_adr;
    logic [B-1:0]   sram_wr_be;

    sram_tp_be_arb dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_be(wr_be), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_adr(rd_adr), .rd_gnt(rd_gnt),
        .rd_vld(rd_vld), .rd_id(rd_id), .rd_dat(rd_dat),
        .sram_wr_ena(sram_wr_ena), .sram_wr_adr(sram_wr_adr), .sram_wr_dat(sram_wr_dat),
        .sram_wr_be(sram_wr_be), .sram_rd_ena(sram_rd_ena), .sram_rd_adr(sram_rd_adr),
        .sram_rd_dat(sram_rd_dat)
    );

    always #5 clk = ~clk;

    // SRAM macro model: read returns pre-write contents one cycle later.
    logic [D-1:0] mem [64];
    logic [D-1:0] rd_q;
    assign sram_rd_dat = rd_q;
    always @(posedge clk) begin
        if (sram_rd_ena) rd_q <= mem[sram_rd_adr];
        if (sram_wr_ena)
            for (int c = 0; c < B; c++)
                if (sram_wr_be[c]) mem[sram_wr_adr][c*C +: C] <= sram_wr_dat[c*C +: C];
    end

    int           checks = 0;
    int           failures = 0;
    logic [D-1:0] ref_mem [64];
    int           m_wr_ptr, m_rd_ptr, pend_id;
    bit           pend_vld;
    logic [D-1:0] pend_dat;
    int           wr_wait [N];
    int           rd_wait [N];
    logic [N-1:0] last_wg, last_rg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int o = 0; o < N; o++)
            if (req[(ptr + o) % N]) return (ptr + o) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        pend_vld = 0;
        pend_id  = 0;
        pend_dat = '0;
        for (int i = 0; i < N; i++) begin
            wr_wait[i] = 0;
            rd_wait[i] = 0;
        end
    endtask

    // Called at the falling edge: compares all outputs with the model, then advances the model.
    task automatic check_cycle();
        int           ew, er, ra, wa;
        logic [N-1:0] ewg, erg;
        logic [D-1:0] od;
        ew  = pick(wr_req, m_wr_ptr);
        er  = pick(rd_req, m_rd_ptr);
        ewg = (ew >= 0) ? (N'(1) << ew) : '0;
        erg = (er >= 0) ? (N'(1) << er) : '0;
        chk("wr_gnt", 64'(wr_gnt), 64'(ewg));
        chk("rd_gnt", 64'(rd_gnt), 64'(erg));
        chk("sram_wr_ena", 64'(sram_wr_ena), 64'(ew >= 0));
        chk("sram_rd_ena", 64'(sram_rd_ena), 64'(er >= 0));
        chk("sram_wr_adr", 64'(sram_wr_adr), (ew >= 0) ? 64'(wr_adr[ew*A +: A]) : 64'd0);
        chk("sram_wr_dat", 64'(sram_wr_dat), (ew >= 0) ? 64'(wr_dat[ew*D +: D]) : 64'd0);
        chk("sram_wr_be", 64'(sram_wr_be), (ew >= 0) ? 64'(wr_be[ew*B +: B]) : 64'd0);
        chk("sram_rd_adr", 64'(sram_rd_adr), (er >= 0) ? 64'(rd_adr[er*A +: A]) : 64'd0);
        chk("rd_vld", 64'(rd_vld), 64'(pend_vld));
        if (pend_vld) begin
            chk("rd_id", 64'(rd_id), 64'(pend_id));
            chk("rd_dat", 64'(rd_dat), 64'(pend_dat));
        end
        for (int i = 0; i < N; i++) begin
            if (!wr_req[i] || ew == i) wr_wait[i] = 0;
            else if (ew >= 0) begin
                wr_wait[i]++;
                chk("wr_fair", 64'(wr_wait[i] <= N - 1), 64'd1);
            end
            if (!rd_req[i] || er == i) rd_wait[i] = 0;
            else if (er >= 0) begin
                rd_wait[i]++;
                chk("rd_fair", 64'(rd_wait[i] <= N - 1), 64'd1);
            end
        end
        pend_vld = (er >= 0);
        if (er >= 0) begin
            ra = int'(rd_adr[er*A +: A]);
            od = ref_mem[ra];
            if (BYP && ew >= 0 && int'(wr_adr[ew*A +: A]) == ra)
                for (int c = 0; c < B; c++)
                    if (wr_be[ew*B + c]) od[c*C +: C] = wr_dat[ew*D + c*C +: C];
            pend_id  = er;
            pend_dat = od;
            m_rd_ptr = (er + 1) % N;
        end
        if (ew >= 0) begin
            wa = int'(wr_adr[ew*A +: A]);
            for (int c = 0; c < B; c++)
                if (wr_be[ew*B + c]) ref_mem[wa][c*C +: C] = wr_dat[ew*D + c*C +: C];
            m_wr_ptr = (ew + 1) % N;
        end
        last_wg = ewg;
        last_rg = erg;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     <= 32'h1000_0000 + i * 32'h0101;
            ref_mem[i]  = 32'h1000_0000 + i * 32'h0101;
        end
        mem[5]     <= 32'hDEAD_BEEF;
        ref_mem[5]  = 32'hDEAD_BEEF;
        mem[7]     <= 32'h1122_3344;
        ref_mem[7]  = 32'h1122_3344;
        rd_q   <= '0;
        rst_n  = 1'b0;
        wr_req = '0; rd_req = '0; wr_adr = '0; rd_adr = '0; wr_dat = '0; wr_be = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("reset_rd_vld", 64'(rd_vld), 64'd0);
        chk("reset_rd_id", 64'(rd_id), 64'd0);
        next();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_wr_gnt", 64'(wr_gnt), 64'd0);
        chk("idle_rd_gnt", 64'(rd_gnt), 64'd0);
        chk("idle_wr_ena", 64'(sram_wr_ena), 64'd0);
        chk("idle_rd_ena", 64'(sram_rd_ena), 64'd0);
        check_cycle();
        next();

        // All four writers held: rotating grant
        wr_req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wr_adr[i*A +: A] = A'(40 + i);
            wr_dat[i*D +: D] = 32'hA000_0000 + i;
            wr_be[i*B +: B]  = 4'hF;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_wr_gnt", 64'(wr_gnt), 64'(4'b0001 << (c % 4)));
            chk("rr_wr_adr", 64'(sram_wr_adr), 64'(40 + c % 4));
            check_cycle();
            next();
        end
        wr_req = '0;

        // Single read by requester 2
        rd_req = 4'b0100;
        rd_adr[2*A +: A] = 6'd5;
        @(negedge clk);
        chk("rd2_gnt", 64'(rd_gnt), 64'(4'b0100));
        check_cycle();
        next();
        rd_req = '0;
        @(negedge clk);
        chk("rd2_vld", 64'(rd_vld), 64'd1);
        chk("rd2_id", 64'(rd_id), 64'd2);
        chk("rd2_dat", 64'(rd_dat), 64'(32'hDEAD_BEEF));
        check_cycle();
        next();

        // Same-address read (req 1) and write (req 3)
        rd_req = 4'b0010;
        rd_adr[1*A +: A] = 6'd7;
        wr_req = 4'b1000;
        wr_adr[3*A +: A] = 6'd7;
        wr_dat[3*D +: D] = 32'hAABB_CCDD;
        wr_be[3*B +: B]  = 4'b0011;
        @(negedge clk);
        check_cycle();
        next();
        wr_req = '0;
        rd_req = 4'b0001;
        rd_adr[0 +: A] = 6'd7;
        @(negedge clk);
        chk("coll_id", 64'(rd_id), 64'd1);
        chk("coll_dat", 64'(rd_dat), BYP ? 64'(32'h1122_CCDD) : 64'(32'h1122_3344));
        check_cycle();
        next();
        rd_req = '0;
        @(negedge clk);
        chk("after_coll_dat", 64'(rd_dat), 64'(32'h1122_CCDD));
        check_cycle();
        next();

        // Reset pulsed right after a read grant
        rd_req = 4'b0100;
        rd_adr[2*A +: A] = 6'd5;
        @(negedge clk);
        check_cycle();
        rst_n = 1'b0;
        model_reset();
        next();
        rst_n = 1'b1;
        rd_req = 4'b1111;
        wr_req = 4'b1111;
        @(negedge clk);
        chk("rst_rd_vld", 64'(rd_vld), 64'd0);
        chk("rst_rd_gnt", 64'(rd_gnt), 64'(4'b0001));
        chk("rst_wr_gnt", 64'(wr_gnt), 64'(4'b0001));
        check_cycle();
        next();

        // Random traffic; requesters hold until granted, occasionally drop
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (wr_req[i] && !last_wg[i]) begin
                    if ($urandom_range(0, 15) == 0) wr_req[i] = 1'b0;
                end else begin
                    wr_req[i] = 1'($urandom_range(0, 1));
                    if (wr_req[i]) begin
                        wr_adr[i*A +: A] = A'($urandom_range(0, 7));
                        wr_dat[i*D +: D] = $urandom;
                        wr_be[i*B +: B]  = B'($urandom_range(0, 15));
                    end
                end
                if (rd_req[i] && !last_rg[i]) begin
                    if ($urandom_range(0, 15) == 0) rd_req[i] = 1'b0;
                end else begin
                    rd_req[i] = 1'($urandom_range(0, 1));
                    if (rd_req[i]) rd_adr[i*A +: A] = A'($urandom_range(0, 7));
                end
            end
            @(negedge clk);
            check_cycle();
            next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
